// File: rtl/shift_latch_reg.sv
`default_nettype none
// ============================================================================
// Module   : shift_latch_reg
// Brief    : Serial-in / parallel-out shift register with storage latch,
//            selectable bit order, cascadable stages, frame bit counter,
//            frame-done pulse and optional automatic latch at end of frame.
// Revision : 1.0 - initial release
// ============================================================================
module shift_latch_reg #(
    parameter int WIDTH      = 8,
    parameter int STAGES     = 1,
    parameter int LSB_FIRST  = 0,
    parameter int AUTO_LATCH = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ser,
    input  logic                                  shift_en,
    input  logic                                  latch,
    input  logic                                  sclr,
    input  logic                                  oe_n,
    output logic [WIDTH*STAGES-1:0]               q,
    output logic                                  ser_out,
    output logic [$clog2(WIDTH*STAGES+1)-1:0]     bit_cnt,
    output logic                                  frame_done
);

    localparam int N  = WIDTH * STAGES;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] C_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [N-1:0]  r_sr;
    logic [N-1:0]  r_st;
    logic [CW-1:0] r_bit_cnt;
    logic          r_frame_done;

    logic [N-1:0]  w_sr_next;
    logic          w_shift;
    logic          w_wrap;

    // Direction of travel through the register is fixed at elaboration time.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_sr_next = {ser, r_sr[N-1:1]};
            assign ser_out   = r_sr[0];
        end else begin : g_msb_first
            assign w_sr_next = {r_sr[N-2:0], ser};
            assign ser_out   = r_sr[N-1];
        end
    endgenerate

    // Clear beats shift, so a cleared cycle never counts as a shift.
    assign w_shift = shift_en & ~sclr;
    assign w_wrap  = w_shift & (r_bit_cnt == C_LAST);

    // Shift register: synchronous clear has priority over shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (sclr) begin
            r_sr <= '0;
        end else if (shift_en) begin
            r_sr <= w_sr_next;
        end
    end

    // Frame bit counter wraps modulo N; the wrap raises a one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (sclr) begin
                r_bit_cnt <= '0;
            end else if (shift_en) begin
                r_bit_cnt <= w_wrap ? '0 : (r_bit_cnt + C_ONE);
            end
        end
    end

    // Storage register: auto latch captures the completed frame (post-shift)
    // and overrides a manual latch, which captures the pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= '0;
        end else if ((AUTO_LATCH != 0) && w_wrap) begin
            r_st <= w_sr_next;
        end else if (latch) begin
            r_st <= r_sr;
        end
    end

    assign q          = oe_n ? '0 : r_st;
    assign bit_cnt    = r_bit_cnt;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
